// File: rtl/io_cmd_master_if.sv
// io_cmd_master_if
//   Bundles the three handshake groups of the IO command master:
//   - command port   : ACmdValid/ACmdReady plus write flag, address, size, data
//   - response port  : ARspValid/ARspReady plus read data, status, write echo
//   - IO bus         : address, write data, one-hot write/read strobes,
//                      read data, address acknowledge and address error
//   modport master : the view used by io_cmd_master itself
//   modport slave  : the view of whoever feeds commands and answers the bus
interface io_cmd_master_if;
    logic        ACmdValid;
    logic        ACmdReady;
    logic        ACmdWr;
    logic [15:0] ACmdAddr;
    logic [1:0]  ACmdSize;
    logic [63:0] ACmdData;

    logic        ARspValid;
    logic        ARspReady;
    logic [63:0] ARspData;
    logic [1:0]  ARspSts;
    logic        ARspWr;

    logic [15:0] AIoAddr;
    logic [63:0] AIoMosi;
    logic [3:0]  AIoWrSize;
    logic [3:0]  AIoRdSize;
    logic [63:0] AIoMiso;
    logic        AIoAddrAck;
    logic        AIoAddrErr;

    modport master (
        input  ACmdValid, ACmdWr, ACmdAddr, ACmdSize, ACmdData,
        input  ARspReady,
        input  AIoMiso, AIoAddrAck, AIoAddrErr,
        output ACmdReady,
        output ARspValid, ARspData, ARspSts, ARspWr,
        output AIoAddr, AIoMosi, AIoWrSize, AIoRdSize
    );

    modport slave (
        output ACmdValid, ACmdWr, ACmdAddr, ACmdSize, ACmdData,
        output ARspReady,
        output AIoMiso, AIoAddrAck, AIoAddrErr,
        input  ACmdReady,
        input  ARspValid, ARspData, ARspSts, ARspWr,
        input  AIoAddr, AIoMosi, AIoWrSize, AIoRdSize
    );
endinterface

// File: rtl/io_cmd_master.sv
// io_cmd_master
//   Initiator for the on-chip IO bus, used by the debug/boot path to reach
//   peripheral registers without the CPU. Takes one command at a time, drives
//   one bus access with a bounded wait for the address acknowledge, and returns
//   the read data and a status code on the response port.
// Ports
//   AClkH    : clock
//   AResetH  : synchronous active-high reset, honoured only on enabled edges
//   AClkHEn  : clock enable, state advances only when 1
//   bus      : command, response and IO bus signals (io_cmd_master_if.master)
//   AErrCnt  : saturating count of responses whose status is not ok
module io_cmd_master #(
    parameter int CWaitMax = 15,
    parameter int CErrCntW = 8
) (
    input  logic                AClkH,
    input  logic                AResetH,
    input  logic                AClkHEn,
    io_cmd_master_if.master     bus,
    output logic [CErrCntW-1:0] AErrCnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RSP
    } state_t;

    localparam logic [1:0] STS_OK      = 2'b00;
    localparam logic [1:0] STS_ADDRERR = 2'b01;
    localparam logic [1:0] STS_TIMEOUT = 2'b10;

    state_t               state_q,    state_d;
    logic                 wr_q,       wr_d;
    logic [1:0]           size_q,     size_d;
    logic [7:0]           wait_q,     wait_d;
    logic [15:0]          io_addr_q,  io_addr_d;
    logic [63:0]          io_mosi_q,  io_mosi_d;
    logic [3:0]           wr_size_q,  wr_size_d;
    logic [3:0]           rd_size_q,  rd_size_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [63:0]          rsp_data_q, rsp_data_d;
    logic [1:0]           rsp_sts_q,  rsp_sts_d;
    logic                 rsp_wr_q,   rsp_wr_d;
    logic [CErrCntW-1:0]  err_cnt_q,  err_cnt_d;

    logic                 do_exit;
    logic [1:0]           exit_sts;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [3:0] size_onehot(input logic [1:0] size);
        size_onehot = 4'b0001 << size;
    endfunction

    // Next-state logic. The bus outputs are loaded on command acceptance so
    // the strobe is already registered in the first Bus cycle; every exit from
    // Bus clears the bus back to idle in the same edge that raises ARspValid.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        size_d      = size_q;
        wait_d      = wait_q;
        io_addr_d   = io_addr_q;
        io_mosi_d   = io_mosi_q;
        wr_size_d   = wr_size_q;
        rd_size_d   = rd_size_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_sts_d   = rsp_sts_q;
        rsp_wr_d    = rsp_wr_q;
        err_cnt_d   = err_cnt_q;
        do_exit     = 1'b0;
        exit_sts    = STS_OK;

        case (state_q)
            ST_IDLE: begin
                if (bus.ACmdValid) begin
                    wr_d      = bus.ACmdWr;
                    size_d    = bus.ACmdSize;
                    wait_d    = 8'd0;
                    io_addr_d = bus.ACmdAddr;
                    if (bus.ACmdWr) begin
                        io_mosi_d = bus.ACmdData & size_mask(bus.ACmdSize);
                        wr_size_d = size_onehot(bus.ACmdSize);
                        rd_size_d = 4'b0000;
                    end else begin
                        io_mosi_d = 64'd0;
                        wr_size_d = 4'b0000;
                        rd_size_d = size_onehot(bus.ACmdSize);
                    end
                    state_d = ST_BUS;
                end
            end

            ST_BUS: begin
                // Error outranks acknowledge; the timeout only fires once the
                // responder has had CWaitMax+1 strobe cycles to answer.
                rsp_data_d = 64'd0;
                if (bus.AIoAddrErr) begin
                    do_exit  = 1'b1;
                    exit_sts = STS_ADDRERR;
                end else if (bus.AIoAddrAck) begin
                    do_exit  = 1'b1;
                    exit_sts = STS_OK;
                    if (!wr_q) begin
                        rsp_data_d = bus.AIoMiso & size_mask(size_q);
                    end
                end else if (wait_q == 8'(CWaitMax)) begin
                    do_exit  = 1'b1;
                    exit_sts = STS_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end

                if (do_exit) begin
                    io_addr_d   = 16'd0;
                    io_mosi_d   = 64'd0;
                    wr_size_d   = 4'b0000;
                    rd_size_d   = 4'b0000;
                    rsp_valid_d = 1'b1;
                    rsp_sts_d   = exit_sts;
                    rsp_wr_d    = wr_q;
                    state_d     = ST_RSP;
                    if (exit_sts != STS_OK && err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end else begin
                    rsp_data_d = rsp_data_q;
                end
            end

            ST_RSP: begin
                if (bus.ARspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. Disabled edges hold everything, including reset, so a
    // reset pulse only takes effect on an enabled edge.
    always_ff @(posedge AClkH) begin
        if (AClkHEn) begin
            if (AResetH) begin
                state_q     <= ST_IDLE;
                wr_q        <= 1'b0;
                size_q      <= 2'd0;
                wait_q      <= 8'd0;
                io_addr_q   <= 16'd0;
                io_mosi_q   <= 64'd0;
                wr_size_q   <= 4'b0000;
                rd_size_q   <= 4'b0000;
                rsp_valid_q <= 1'b0;
                rsp_data_q  <= 64'd0;
                rsp_sts_q   <= 2'b00;
                rsp_wr_q    <= 1'b0;
                err_cnt_q   <= '0;
            end else begin
                state_q     <= state_d;
                wr_q        <= wr_d;
                size_q      <= size_d;
                wait_q      <= wait_d;
                io_addr_q   <= io_addr_d;
                io_mosi_q   <= io_mosi_d;
                wr_size_q   <= wr_size_d;
                rd_size_q   <= rd_size_d;
                rsp_valid_q <= rsp_valid_d;
                rsp_data_q  <= rsp_data_d;
                rsp_sts_q   <= rsp_sts_d;
                rsp_wr_q    <= rsp_wr_d;
                err_cnt_q   <= err_cnt_d;
            end
        end
    end

    assign bus.ACmdReady = (state_q == ST_IDLE);
    assign bus.ARspValid = rsp_valid_q;
    assign bus.ARspData  = rsp_data_q;
    assign bus.ARspSts   = rsp_sts_q;
    assign bus.ARspWr    = rsp_wr_q;
    assign bus.AIoAddr   = io_addr_q;
    assign bus.AIoMosi   = io_mosi_q;
    assign bus.AIoWrSize = wr_size_q;
    assign bus.AIoRdSize = rd_size_q;
    assign AErrCnt       = err_cnt_q;

endmodule
